// File: rtl/calc_pkg.sv
// Shared definitions for the calculator input path.
// Holds the operation codes that select what the sign-conversion unit
// does to each operand.
package calc_pkg;

    // Operation codes carried alongside each operand.
    localparam logic [1:0] MODE_NEG   = 2'd0;  // two's-complement negate
    localparam logic [1:0] MODE_ABS   = 2'd1;  // absolute value
    localparam logic [1:0] MODE_SM2TC = 2'd2;  // sign-magnitude to two's complement
    localparam logic [1:0] MODE_TC2SM = 2'd3;  // two's complement to sign-magnitude

endpackage

// File: rtl/complement_core.sv
// Combinational sign-conversion datapath.
// A single negate carry chain is shared by all four operations; the mode
// selects which value is fed into the chain and how the result is formed.
//
// Ports:
//   x    in   N  operand
//   mode in   2  operation code (see calc_pkg)
//   y    out  N  converted result
//   ovf  out  1  result cannot be represented in N bits
module complement_core
    import calc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [1:0]   mode,
    output logic [N-1:0] y,
    output logic         ovf
);

    logic [N-1:0] neg_in;
    logic [N-1:0] neg_out;
    logic [N-1:0] carry;
    logic         is_min;
    logic         run;

    // The most negative value has no positive counterpart.
    assign is_min = (x == {1'b1, {(N-1){1'b0}}});

    // Sign-magnitude input negates only the magnitude field; every other
    // mode negates the operand as a whole.
    always_comb begin
        neg_in = x;
        if (mode == MODE_SM2TC) begin
            neg_in = {1'b0, x[N-2:0]};
        end
    end

    // Increment of the inverted operand: a carry reaches bit i only when
    // every lower bit of the operand is zero. The running AND avoids
    // feeding a vector back into itself.
    always_comb begin
        run = 1'b1;
        for (int i = 0; i < N; i++) begin
            carry[i] = run;
            run      = run & ~neg_in[i];
        end
        neg_out = ~neg_in ^ carry;
    end

    // Result formation per operation. Negative zero in sign-magnitude has
    // a zero magnitude, so its negation is 0 and it never overflows.
    always_comb begin
        y   = neg_out;
        ovf = 1'b0;
        case (mode)
            MODE_NEG: begin
                y   = neg_out;
                ovf = is_min;
            end
            MODE_ABS: begin
                y   = x[N-1] ? neg_out : x;
                ovf = is_min;
            end
            MODE_SM2TC: begin
                y   = x[N-1] ? neg_out : neg_in;
                ovf = 1'b0;
            end
            MODE_TC2SM: begin
                y   = x[N-1] ? {1'b1, neg_out[N-2:0]} : x;
                ovf = is_min;
            end
            default: begin
                y   = neg_out;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sign_convert_pipe.sv
// Two-stage pipelined sign-conversion unit with valid/ready flow control.
// Stage 1 captures the raw operand and mode; stage 2 captures the converted
// result and its overflow flag. A sticky flag remembers any overflowing
// result handed downstream until it is cleared.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operand present
//   in_ready   out  1  operand accepted this cycle
//   in_data    in   N  operand
//   in_mode    in   2  operation code
//   out_valid  out  1  result present
//   out_ready  in   1  downstream accepts result
//   out_data   out  N  result
//   out_ovf    out  1  result not representable
//   ovf_sticky out  1  any overflowing result delivered since reset/clear
//   ovf_clear  in   1  synchronous clear of ovf_sticky
module sign_convert_pipe
    import calc_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf,
    output logic         ovf_sticky,
    input  logic         ovf_clear
);

    // The register depth is fixed; reject any other configuration early.
    if (STAGES != 2) begin : g_bad_stages
        $error("sign_convert_pipe: STAGES must be 2");
    end
    if (N < 2) begin : g_bad_width
        $error("sign_convert_pipe: N must be at least 2");
    end

    logic         s1_v;
    logic [N-1:0] s1_data;
    logic [1:0]   s1_mode;
    logic         s2_v;
    logic [N-1:0] s2_data;
    logic         s2_ovf;
    logic         adv1;
    logic [N-1:0] core_y;
    logic         core_ovf;

    // Each stage may take new data when it is empty or when the stage
    // after it is emptying this cycle. Neither term looks at in_valid.
    assign adv1     = !s2_v || out_ready;
    assign in_ready = !s1_v || adv1;

    complement_core #(.N(N)) u_core (
        .x    (s1_data),
        .mode (s1_mode),
        .y    (core_y),
        .ovf  (core_ovf)
    );

    // Stage 1: raw operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_mode <= MODE_NEG;
        end else if (in_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
            end
        end
    end

    // Stage 2: converted result register. Data only moves on a load, so a
    // stalled result stays put until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_data <= '0;
            s2_ovf  <= 1'b0;
        end else if (adv1) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_data <= core_y;
                s2_ovf  <= core_ovf;
            end
        end
    end

    // Sticky overflow: a delivered overflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (s2_v && out_ready && s2_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky <= 1'b0;
        end
    end

    assign out_valid = s2_v;
    assign out_data  = s2_data;
    assign out_ovf   = s2_ovf;

endmodule

// File: tb/tb_sign_convert_pipe.sv
// Directed self-checking bench for sign_convert_pipe at N = 8.
// Each scenario task drives its own stimulus and compares against
// hand-computed expected values.
module tb_sign_convert_pipe;

    localparam logic [1:0] M_NEG   = 2'd0;
    localparam logic [1:0] M_ABS   = 2'd1;
    localparam logic [1:0] M_SM2TC = 2'd2;
    localparam logic [1:0] M_TC2SM = 2'd3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       ovf_sticky;
    logic       ovf_clear;

    int vec_count;
    int miscompares;

    // Stream stimulus and capture buffers.
    logic [7:0] stim_data [8];
    logic [1:0] stim_mode [8];
    logic [7:0] got_data  [8];
    logic       got_ovf   [8];
    int         acc_cyc   [8];
    int         emit_cyc  [8];
    logic       rdy_trace [64];
    int         stall_accepts;
    bit         hold_bad;
    bit         stream_timeout;

    sign_convert_pipe #(.N(8), .STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clear  (ovf_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single operand through an otherwise idle pipe. Returns the result and
    // the number of edges from the accept edge to the output handshake edge.
    task automatic run_one(input logic [1:0] m, input logic [7:0] d,
                           output logic [7:0] rd, output logic ro,
                           output int lat, output bit to);
        int n;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #2;
            lat++;
        end
        to = !out_valid;
        rd = out_data;
        ro = out_ovf;
        @(posedge clk); #1;
    endtask

    // One cycle of ovf_clear with nothing else happening.
    task automatic pulse_clear();
        @(posedge clk); #1;
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
    endtask

    // Streams n operands from the stim buffers; out_ready is low during
    // cycles [stall_start, stall_start+stall_len). Records what came out.
    task automatic stream(input int n, input int stall_start, input int stall_len);
        int         tx;
        int         rx;
        int         cyc;
        bit         in_fire;
        bit         out_fire;
        bit         prev_stalled;
        logic [7:0] prev_data;
        tx = 0; rx = 0; cyc = 0;
        stall_accepts  = 0;
        hold_bad       = 1'b0;
        prev_stalled   = 1'b0;
        prev_data      = '0;
        @(posedge clk); #1;
        while (rx < n && cyc < 60) begin
            in_valid  = (tx < n);
            in_data   = stim_data[(tx < n) ? tx : 0];
            in_mode   = stim_mode[(tx < n) ? tx : 0];
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            #1;
            rdy_trace[cyc] = in_ready;
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (in_fire) begin
                acc_cyc[tx] = cyc;
                if (!out_ready) stall_accepts++;
            end
            if (out_fire) begin
                got_data[rx] = out_data;
                got_ovf[rx]  = out_ovf;
                emit_cyc[rx] = cyc;
            end
            if (prev_stalled && out_valid && out_data != prev_data) hold_bad = 1'b1;
            prev_stalled = out_valid && !out_ready;
            prev_data    = out_data;
            @(posedge clk); #1;
            if (in_fire) tx++;
            if (out_fire) rx++;
            cyc++;
        end
        stream_timeout = (rx < n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = M_NEG;
        out_ready = 1'b1;
        ovf_clear = 1'b0;
        #12;
        vec_count++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ovf !== 1'b0 || ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: valid=%b data=%h ovf=%b sticky=%b, required 0 00 0 0",
                     out_valid, out_data, out_ovf, ovf_sticky);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vec_count++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_negate();
        logic [7:0] rd;
        logic       ro;
        int         lat;
        bit         to;
        run_one(M_NEG, 8'h05, rd, ro, lat, to);
        vec_count++;
        if (to || rd !== 8'hFB || ro !== 1'b0 || lat != 2) begin
            miscompares++;
            $display("[TB] FAIL neg_05: data=%h ovf=%b lat=%0d to=%b, required FB 0 2 0", rd, ro, lat, to);
        end
        vec_count++;
        if (ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sticky_quiet: got %b, required 0", ovf_sticky);
        end
        run_one(M_NEG, 8'h80, rd, ro, lat, to);
        vec_count++;
        if (to || rd !== 8'h80 || ro !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL neg_80: data=%h ovf=%b to=%b, required 80 1 0", rd, ro, to);
        end
        vec_count++;
        if (ovf_sticky !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sticky_set: got %b, required 1", ovf_sticky);
        end
        run_one(M_NEG, 8'h00, rd, ro, lat, to);
        vec_count++;
        if (to || rd !== 8'h00 || ro !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL neg_00: data=%h ovf=%b to=%b, required 00 0 0", rd, ro, to);
        end
        vec_count++;
        if (ovf_sticky !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sticky_hold: got %b, required 1", ovf_sticky);
        end
    endtask

    task automatic test_modes();
        logic [1:0] modes [8];
        logic [7:0] ins   [8];
        logic [7:0] exps  [8];
        logic       ovfs  [8];
        logic [7:0] rd;
        logic       ro;
        int         lat;
        bit         to;
        modes = '{M_ABS, M_ABS, M_ABS, M_SM2TC, M_SM2TC, M_SM2TC, M_TC2SM, M_TC2SM};
        ins   = '{8'hFF, 8'h05, 8'h80, 8'h85, 8'h80, 8'h05, 8'hFB, 8'h80};
        exps  = '{8'h01, 8'h05, 8'h80, 8'hFB, 8'h00, 8'h05, 8'h85, 8'h80};
        ovfs  = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        for (int i = 0; i < 8; i++) begin
            run_one(modes[i], ins[i], rd, ro, lat, to);
            vec_count++;
            if (to || rd !== exps[i] || ro !== ovfs[i]) begin
                miscompares++;
                $display("[TB] FAIL mode%0d_%h: data=%h ovf=%b to=%b, required %h %b 0",
                         modes[i], ins[i], rd, ro, to, exps[i], ovfs[i]);
            end
        end
        run_one(M_TC2SM, 8'h05, rd, ro, lat, to);
        vec_count++;
        if (to || rd !== 8'h05 || ro !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tc2sm_05: data=%h ovf=%b, required 05 0", rd, ro);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exps [8];
        stim_data = '{8'h01, 8'h02, 8'h03, 8'h7F, 8'h10, 8'h20, 8'h40, 8'h00};
        exps      = '{8'hFF, 8'hFE, 8'hFD, 8'h81, 8'hF0, 8'hE0, 8'hC0, 8'h00};
        for (int i = 0; i < 8; i++) stim_mode[i] = M_NEG;
        stream(8, 0, 0);
        vec_count++;
        if (stream_timeout) begin
            miscompares++;
            $display("[TB] FAIL b2b_timeout: results missing, required 8");
        end else begin
            vec_count++;
            if (emit_cyc[0] - acc_cyc[0] != 2) begin
                miscompares++;
                $display("[TB] FAIL b2b_latency: got %0d, required 2", emit_cyc[0] - acc_cyc[0]);
            end
            for (int i = 0; i < 8; i++) begin
                vec_count++;
                if (got_data[i] !== exps[i] || emit_cyc[i] != emit_cyc[0] + i) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_%0d: data=%h cyc=%0d, required %h cyc=%0d",
                             i, got_data[i], emit_cyc[i], exps[i], emit_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exps [6];
        stim_data[0] = 8'h01; stim_mode[0] = M_NEG;   exps[0] = 8'hFF;
        stim_data[1] = 8'h81; stim_mode[1] = M_ABS;   exps[1] = 8'h7F;
        stim_data[2] = 8'h83; stim_mode[2] = M_SM2TC; exps[2] = 8'hFD;
        stim_data[3] = 8'hFE; stim_mode[3] = M_TC2SM; exps[3] = 8'h82;
        stim_data[4] = 8'h7F; stim_mode[4] = M_NEG;   exps[4] = 8'h81;
        stim_data[5] = 8'h10; stim_mode[5] = M_ABS;   exps[5] = 8'h10;
        stream(6, 0, 5);
        vec_count++;
        if (stall_accepts != 2) begin
            miscompares++;
            $display("[TB] FAIL bp_accepts: got %0d, required 2", stall_accepts);
        end
        vec_count++;
        if (rdy_trace[2] !== 1'b0 || rdy_trace[4] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_in_ready: cyc2=%b cyc4=%b, required 0 0", rdy_trace[2], rdy_trace[4]);
        end
        vec_count++;
        if (hold_bad) begin
            miscompares++;
            $display("[TB] FAIL bp_hold: out_data changed while stalled, required stable");
        end
        vec_count++;
        if (stream_timeout) begin
            miscompares++;
            $display("[TB] FAIL bp_timeout: results missing, required 6");
        end else begin
            for (int i = 0; i < 6; i++) begin
                vec_count++;
                if (got_data[i] !== exps[i] || got_ovf[i] !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL bp_%0d: data=%h ovf=%b, required %h 0",
                             i, got_data[i], got_ovf[i], exps[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [7:0] rd;
        logic       ro;
        int         lat;
        bit         to;
        bit         seen;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = M_NEG;
        in_data   = 8'h11;
        @(posedge clk); #1;
        in_data   = 8'h22;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        vec_count++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_inflight: out_valid=%b, required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        vec_count++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL mid_async: valid=%b data=%h, required 0 00", out_valid, out_data);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        vec_count++;
        if (seen) begin
            miscompares++;
            $display("[TB] FAIL mid_ghost: out_valid seen after reset, required none");
        end
        run_one(M_NEG, 8'h03, rd, ro, lat, to);
        vec_count++;
        if (to || rd !== 8'hFD || lat != 2) begin
            miscompares++;
            $display("[TB] FAIL mid_next: data=%h lat=%0d to=%b, required FD 2 0", rd, lat, to);
        end
    endtask

    task automatic test_sticky_clear();
        int n;
        pulse_clear();
        vec_count++;
        if (ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clr_pre: got %b, required 0", ovf_sticky);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = M_NEG;
        in_data   = 8'h80;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        vec_count++;
        if (!out_valid || out_ovf !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clr_setup: valid=%b ovf=%b, required 1 1", out_valid, out_ovf);
        end
        out_ready = 1'b1;
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        vec_count++;
        if (ovf_sticky !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clr_set_wins: got %b, required 1", ovf_sticky);
        end
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        vec_count++;
        if (ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clr_alone: got %b, required 0", ovf_sticky);
        end
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
        test_reset();
        test_negate();
        pulse_clear();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_stream();
        test_sticky_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
